fifo_block_serializer: RTL

//  Parametrised block reader for the FIFO on the SDRAM read path. Waits until the FIFO

---
 rtl/fifo_block_serializer.sv | 110 +++++++++++
 1 files changed

// File: rtl/fifo_block_serializer.sv
// Reads one BLOCK_WORDS block from a non-showahead FIFO once enough words are present,
// and serialises every word into WORD_W/8 bytes on a valid/ready byte stream.
`timescale 1ns/1ps
module fifo_block_serializer #(
  parameter int WORD_W      = 16,
  parameter int USEDW_W     = 10,
  parameter int BLOCK_WORDS = 512,
  parameter int MSB_FIRST   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic               fifo_empty,
  input  logic [WORD_W-1:0]  fifo_q,
  output logic               fifo_rdreq,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               abort,
  output logic               busy,
  output logic               block_done,
  output logic               block_aborted
);

  localparam int BYTES = WORD_W / 8;
  localparam int WCW   = $clog2(BLOCK_WORDS + 1);
  localparam int BIW   = $clog2(BYTES) + 1;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DONE} state_t;

  state_t            state_q, state_d;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;
  logic [BIW-1:0]    byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              aborted_q, aborted_d;
  logic              beat;
  logic              last_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      sreg_q     <= '0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      sreg_q     <= sreg_d;
      aborted_q  <= aborted_d;
    end
  end

  assign beat      = (state_q == SEND) && out_ready;
  assign last_byte = (byte_idx_q == BIW'(BYTES - 1));

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    sreg_d     = sreg_q;
    aborted_d  = 1'b0;
    // The read is suppressed on an abort cycle so the word stays in the FIFO.
    fifo_rdreq = (state_q == FETCH) && !fifo_empty && !abort;

    case (state_q)
      IDLE: begin
        word_cnt_d = '0;
        if ((fifo_usedw >= USEDW_W'(BLOCK_WORDS)) && !abort) state_d = FETCH;
      end
      FETCH: if (!fifo_empty) state_d = LOAD;
      LOAD: begin
        sreg_d     = fifo_q;
        byte_idx_d = '0;
        state_d    = SEND;
      end
      SEND: begin
        if (beat) begin
          byte_idx_d = byte_idx_q + 1'b1;
          if (MSB_FIRST != 0) sreg_d = sreg_q << 8;
          else                sreg_d = sreg_q >> 8;
          if (last_byte) begin
            if (word_cnt_q == WCW'(BLOCK_WORDS - 1)) begin
              state_d = DONE;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
              state_d    = FETCH;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition, including the final beat of a block.
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end
  end

  assign out_data      = (MSB_FIRST != 0) ? sreg_q[WORD_W-1 -: 8] : sreg_q[7:0];
  assign out_valid     = (state_q == SEND);
  assign busy          = (state_q != IDLE);
  assign block_done    = (state_q == DONE);
  assign block_aborted = aborted_q;

endmodule
